// File: rtl/sram_1rw_req_adapter_if.sv
// Request/response stream and 1rw SRAM port bundle for sram_1rw_req_adapter.
// master: client plus SRAM macro side; slave: the adapter.
interface sram_1rw_req_adapter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_wmask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  a_re;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_data_in;
  logic [DATA_WIDTH-1:0] a_wmask;
  logic [DATA_WIDTH-1:0] a_data_out;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready, a_data_out,
    input  req_ready, rsp_valid, rsp_rdata, a_re, a_we, a_addr, a_data_in, a_wmask
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, rsp_ready, a_data_out,
    output req_ready, rsp_valid, rsp_rdata, a_re, a_we, a_addr, a_data_in, a_wmask
  );
endinterface

// File: rtl/sram_1rw_req_adapter.sv
// Valid/ready request front-end for a bit-masked 1rw SRAM with a credit-protected read FIFO.
// Optional post-reset zero-fill sweep enabled by `SRAM_ADAPTER_CLEAR_EN.
module sram_1rw_req_adapter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned RESP_DEPTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    busy,
  sram_1rw_req_adapter_if.slave   bus
);
  localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
  localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

  logic                  idle;
  logic                  clearing;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  ready;
  logic                  acc;
  logic                  push;
  logic                  pop;
  logic                  inflight;
  logic [CW-1:0]         count;
  logic [CW:0]           used;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];

`ifdef SRAM_ADAPTER_CLEAR_EN
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && clr_cnt == ADDR_WIDTH'(DEPTH - 1)) state_nxt = IDLE;
  end

  // Reset overrides the sweep so the SRAM port stays quiet while rst is high.
  assign idle     = (state == IDLE);
  assign clearing = (state == CLEAR) & ~rst;
  assign clr_addr = clr_cnt;
  assign busy     = rst | (state == CLEAR);
`else
  assign idle     = 1'b1;
  assign clearing = 1'b0;
  assign clr_addr = '0;
  assign busy     = 1'b0;
`endif

  // Credit counts both queued responses and the read whose data is still in the SRAM.
  assign used  = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign ready = idle & ~rst & (used < (CW + 1)'(RESP_DEPTH));
  assign acc   = bus.req_valid & ready;
  assign push  = inflight;
  assign pop   = bus.rsp_valid & bus.rsp_ready;

  assign bus.req_ready = ready;
  assign bus.rsp_valid = ~rst & (count != '0);
  assign bus.rsp_rdata = fifo_mem[rd_ptr];

  always_comb begin
    bus.a_re      = 1'b0;
    bus.a_we      = 1'b0;
    bus.a_addr    = '0;
    bus.a_data_in = '0;
    bus.a_wmask   = '0;
    if (clearing) begin
      bus.a_we    = 1'b1;
      bus.a_addr  = clr_addr;
      bus.a_wmask = '1;
    end else if (acc) begin
      bus.a_re      = ~bus.req_write;
      bus.a_we      = bus.req_write;
      bus.a_addr    = bus.req_addr;
      bus.a_data_in = bus.req_wdata;
      bus.a_wmask   = bus.req_wmask;
    end
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= acc & ~bus.req_write;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.a_data_out;
  end
endmodule

// File: tb/tb_sram_1rw_req_adapter.sv
// Directed self-checking bench for sram_1rw_req_adapter with a behavioural 32x8 bit-masked SRAM.
module tb_sram_1rw_req_adapter;
  logic clk;
  logic rst;
  logic busy;
  int   ncmp;
  int   nerr;

  sram_1rw_req_adapter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus ();

  sram_1rw_req_adapter #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .DEPTH(32), .RESP_DEPTH(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .busy (busy),
    .bus  (bus)
  );

`ifdef SRAM_ADAPTER_CLEAR_EN
  localparam logic EXP_BUSY_RST = 1'b1;
  localparam logic EXP_READY0   = 1'b0;
  localparam logic EXP_BUSY0    = 1'b1;
`else
  localparam logic EXP_BUSY_RST = 1'b0;
  localparam logic EXP_READY0   = 1'b1;
  localparam logic EXP_BUSY0    = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: output is poisoned except in the cycle after a read.
  logic [7:0] sram [32];
  logic [7:0] sram_q;
  logic       rd_d;
  initial begin
    for (int i = 0; i < 32; i++) sram[i] = 8'h5A;
    rd_d   = 1'b0;
    sram_q = 8'h00;
  end
  always @(posedge clk) begin
    if (bus.a_we) sram[bus.a_addr] <= (sram[bus.a_addr] & ~bus.a_wmask) | (bus.a_data_in & bus.a_wmask);
    if (bus.a_re) sram_q <= sram[bus.a_addr];
    rd_d <= bus.a_re;
  end
  assign bus.a_data_out = rd_d ? sram_q : 8'hEE;

  task automatic drive(input logic v, input logic w, input logic [4:0] a,
                       input logic [7:0] d, input logic [7:0] m);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wmask = m;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    drive(1'b1, 1'b1, 5'd3, 8'hFF, 8'hFF);
    repeat (2) @(negedge clk);
    #1;
    ncmp++; if (bus.req_ready !== 1'b0) begin nerr++; $display("FAIL rst_ready got=%b exp=0", bus.req_ready); end
    ncmp++; if (bus.a_we !== 1'b0 || bus.a_re !== 1'b0) begin nerr++; $display("FAIL rst_sram_en got we=%b re=%b exp 0/0", bus.a_we, bus.a_re); end
    ncmp++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL rst_rsp_valid got=%b exp=0", bus.rsp_valid); end
    ncmp++; if (busy !== EXP_BUSY_RST) begin nerr++; $display("FAIL rst_busy got=%b exp=%b", busy, EXP_BUSY_RST); end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 8'h00, 8'h00);
    #1;
    ncmp++; if (bus.req_ready !== EXP_READY0) begin nerr++; $display("FAIL rel_ready got=%b exp=%b", bus.req_ready, EXP_READY0); end
    ncmp++; if (busy !== EXP_BUSY0) begin nerr++; $display("FAIL rel_busy got=%b exp=%b", busy, EXP_BUSY0); end
  endtask

`ifdef SRAM_ADAPTER_CLEAR_EN
  task automatic test_clear_sweep;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 8'h00, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      ncmp++; if (bus.a_we !== 1'b1 || bus.a_addr !== 5'(c)) begin nerr++; $display("FAIL clr1 c=%0d got we=%b addr=%0d exp 1/%0d", c, bus.a_we, bus.a_addr, c); end
    end
    rst = 1'b1;
    #1;
    ncmp++; if (bus.a_we !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL clr_rst got we=%b busy=%b exp 0/1", bus.a_we, busy); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 32; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      ncmp++;
      if (bus.a_we !== 1'b1 || bus.a_addr !== 5'(c) || bus.a_data_in !== 8'h00 || bus.a_wmask !== 8'hFF ||
          busy !== 1'b1 || bus.req_ready !== 1'b0 || bus.a_re !== 1'b0) begin
        nerr++;
        $display("FAIL clr2 c=%0d got we=%b addr=%0d din=%h mask=%h busy=%b rdy=%b exp 1/%0d/00/ff/1/0", c,
                 bus.a_we, bus.a_addr, bus.a_data_in, bus.a_wmask, busy, bus.req_ready, c);
      end
    end
    @(negedge clk);
    #1;
    ncmp++; if (busy !== 1'b0 || bus.req_ready !== 1'b1 || bus.a_we !== 1'b0) begin nerr++; $display("FAIL clr_done got busy=%b rdy=%b we=%b exp 0/1/0", busy, bus.req_ready, bus.a_we); end
    bus.rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 5'd17, 8'h00, 8'h00);
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 8'h00, 8'h00);
    @(negedge clk);
    #1;
    ncmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'h00) begin nerr++; $display("FAIL clr_read17 got v=%b d=%h exp 1/00", bus.rsp_valid, bus.rsp_rdata); end
    bus.rsp_ready = 1'b1;
  endtask
`endif

  task automatic test_masked_write;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd5, 8'hA5, 8'hFF);
    #1;
    ncmp++; if (bus.a_we !== 1'b1 || bus.a_addr !== 5'd5 || bus.a_data_in !== 8'hA5) begin nerr++; $display("FAIL mw_wr1 got we=%b addr=%0d din=%h exp 1/5/a5", bus.a_we, bus.a_addr, bus.a_data_in); end
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd5, 8'h00, 8'h0F);
    #1;
    ncmp++; if (bus.a_wmask !== 8'h0F || bus.a_re !== 1'b0 || bus.a_we !== 1'b1) begin nerr++; $display("FAIL mw_wr2 got mask=%h re=%b we=%b exp 0f/0/1", bus.a_wmask, bus.a_re, bus.a_we); end
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd5, 8'h00, 8'h00);
    #1;
    ncmp++; if (bus.a_re !== 1'b1 || bus.a_we !== 1'b0) begin nerr++; $display("FAIL mw_rd got re=%b we=%b exp 1/0", bus.a_re, bus.a_we); end
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 8'h00, 8'h00);
    #1;
    ncmp++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL mw_lat1 got=%b exp=0", bus.rsp_valid); end
    @(negedge clk);
    #1;
    ncmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'hA0) begin nerr++; $display("FAIL mw_rsp got v=%b d=%h exp 1/a0", bus.rsp_valid, bus.rsp_rdata); end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    ncmp++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL mw_pop got=%b exp=0", bus.rsp_valid); end
  endtask

  task automatic test_back_to_back;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 5'(i), 8'h10 + 8'(i), 8'hFF);
      #1;
      ncmp++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL b2b_wr i=%0d got=%b exp=1", i, bus.req_ready); end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c < 8) drive(1'b1, 1'b0, 5'(c), 8'h00, 8'h00);
      else       drive(1'b0, 1'b0, 5'd0, 8'h00, 8'h00);
      #1;
      if (c < 8) begin
        ncmp++; if (bus.req_ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready c=%0d got=%b exp=1", c, bus.req_ready); end
      end
      if (c >= 2) begin
        ncmp++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'h10 + 8'(c - 2)) begin
          nerr++; $display("FAIL b2b_rsp c=%0d got v=%b d=%h exp 1/%h", c, bus.rsp_valid, bus.rsp_rdata, 8'h10 + 8'(c - 2));
        end
      end else begin
        ncmp++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL b2b_early c=%0d got=%b exp=0", c, bus.rsp_valid); end
      end
    end
    @(negedge clk);
    #1;
    ncmp++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL b2b_end got=%b exp=0", bus.rsp_valid); end
  endtask

  task automatic test_backpressure;
    int k;
    logic exp_rdy;
    k = 0;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, (c < 3) ? 5'(c) : 5'd3, 8'h00, 8'h00);
      #1;
      exp_rdy = (c < 3);
      ncmp++; if (bus.req_ready !== exp_rdy || bus.a_re !== exp_rdy) begin nerr++; $display("FAIL bp_stall c=%0d got rdy=%b re=%b exp %b/%b", c, bus.req_ready, bus.a_re, exp_rdy, exp_rdy); end
    end
    for (int c = 8; c < 16; c++) begin
      @(negedge clk);
      if (c == 8) bus.rsp_ready = 1'b1;
      if (c <= 9)       drive(1'b1, 1'b0, 5'd3, 8'h00, 8'h00);
      else if (c == 10) drive(1'b1, 1'b0, 5'd4, 8'h00, 8'h00);
      else              drive(1'b0, 1'b0, 5'd0, 8'h00, 8'h00);
      #1;
      if (c <= 10) begin
        exp_rdy = (c != 8);
        ncmp++; if (bus.req_ready !== exp_rdy || bus.a_re !== exp_rdy) begin nerr++; $display("FAIL bp_drain c=%0d got rdy=%b re=%b exp %b/%b", c, bus.req_ready, bus.a_re, exp_rdy, exp_rdy); end
      end
      if (bus.rsp_valid === 1'b1) begin
        ncmp++; if (bus.rsp_rdata !== 8'h10 + 8'(k)) begin nerr++; $display("FAIL bp_rsp k=%0d got=%h exp=%h", k, bus.rsp_rdata, 8'h10 + 8'(k)); end
        k++;
      end
    end
    ncmp++; if (k !== 5) begin nerr++; $display("FAIL bp_count got=%0d exp=5", k); end
  endtask

  task automatic test_write_then_read;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd9, 8'h3C, 8'hFF);
    #1;
    ncmp++; if (bus.req_ready !== 1'b1 || bus.a_we !== 1'b1) begin nerr++; $display("FAIL wr_rd_w got rdy=%b we=%b exp 1/1", bus.req_ready, bus.a_we); end
    @(negedge clk);
    drive(1'b1, 1'b0, 5'd9, 8'h00, 8'h00);
    #1;
    ncmp++; if (bus.a_re !== 1'b1 || bus.a_addr !== 5'd9) begin nerr++; $display("FAIL wr_rd_r got re=%b addr=%0d exp 1/9", bus.a_re, bus.a_addr); end
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 8'h00, 8'h00);
    #1;
    ncmp++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL wr_nopush got=%b exp=0", bus.rsp_valid); end
    @(negedge clk);
    #1;
    ncmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'h3C) begin nerr++; $display("FAIL wr_rd_rsp got v=%b d=%h exp 1/3c", bus.rsp_valid, bus.rsp_rdata); end
    @(negedge clk);
    #1;
    ncmp++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL wr_rd_end got=%b exp=0", bus.rsp_valid); end
  endtask

  task automatic test_reset_mid_op;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 5'(c), 8'h00, 8'h00);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 5'd0, 8'h00, 8'h00);
    #1;
    ncmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'h10) begin nerr++; $display("FAIL rmo_queued got v=%b d=%h exp 1/10", bus.rsp_valid, bus.rsp_rdata); end
    rst = 1'b1;
    #1;
    ncmp++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin nerr++; $display("FAIL rmo_rst got v=%b rdy=%b exp 0/0", bus.rsp_valid, bus.req_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    ncmp++; if (bus.req_ready !== EXP_READY0) begin nerr++; $display("FAIL rmo_ready got=%b exp=%b", bus.req_ready, EXP_READY0); end
    for (int c = 0; c < 5; c++) begin
      ncmp++; if (bus.rsp_valid !== 1'b0) begin nerr++; $display("FAIL rmo_stale c=%0d got=%b exp=0", c, bus.rsp_valid); end
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    rst  = 1'b1;
    bus.rsp_ready = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 8'h00, 8'h00);
    test_reset();
`ifdef SRAM_ADAPTER_CLEAR_EN
    test_clear_sweep();
`endif
    test_masked_write();
    test_back_to_back();
    test_backpressure();
    test_write_then_read();
    test_reset_mid_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
